// File: rtl/hazard_scoreboard_if.sv
// Hazard-controller bundle: ID-stage decode, EXE branch decision, global hold
// in; stall/bubble/flush controls and performance counters out.
interface hazard_scoreboard_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_use_src2;
  logic             id_wb_en;
  logic [4:0]       id_dest;
  logic             id_mem_read;
  logic             br_taken;
  logic             mem_freeze;
  logic             stall;
  logic             bubble;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_use_src2, id_wb_en, id_dest,
           id_mem_read, br_taken, mem_freeze,
    input  stall, bubble, flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_use_src2, id_wb_en, id_dest,
           id_mem_read, br_taken, mem_freeze,
    output stall, bubble, flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Five-stage pipeline hazard controller: tracks EXE/MEM/WB destinations in a
// shift scoreboard and raises stall, bubble and flush for the ID stage.
module hazard_scoreboard #(
  parameter bit          FWD_EN       = 1'b0,
  parameter bit          WB_BYPASS    = 1'b1,
  parameter bit          R0_HARDWIRED = 1'b0,
  parameter int unsigned CNT_W        = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_scoreboard_if.slave sb
);

  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       ld;
  } sb_entry_t;

  sb_entry_t        e_q, e_d;
  sb_entry_t        m_q, m_d;
  sb_entry_t        w_q, w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hit_e, hit_m, hit_w;
  logic hz;
  logic stall, flush, bubble;

  function automatic logic src_match(input sb_entry_t x, input logic [4:0] src);
    src_match = x.v && (x.dest == src) && !(R0_HARDWIRED && (x.dest == 5'd0));
  endfunction

  function automatic logic entry_hit(input sb_entry_t x, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic use2);
    entry_hit = src_match(x, s1) || (use2 && src_match(x, s2));
  endfunction

  always_comb begin
    hit_e = entry_hit(e_q, sb.id_src1, sb.id_src2, sb.id_use_src2);
    hit_m = entry_hit(m_q, sb.id_src1, sb.id_src2, sb.id_use_src2);
    hit_w = entry_hit(w_q, sb.id_src1, sb.id_src2, sb.id_use_src2);
    if (FWD_EN) begin
      hz = sb.id_valid && e_q.ld && hit_e;
    end else begin
      hz = sb.id_valid && (hit_e || hit_m || (!WB_BYPASS && hit_w));
    end
    // Flush wins over stall: the stalled instruction is being killed anyway.
    flush  = sb.br_taken && !rst;
    stall  = hz && !sb.br_taken && !rst;
    bubble = stall || flush;
  end

  always_comb begin
    e_d         = e_q;
    m_d         = m_q;
    w_d         = w_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!sb.mem_freeze) begin
      w_d = m_q;
      m_d = e_q;
      e_d = '0;
      if (sb.id_valid && sb.id_wb_en && !bubble) begin
        e_d.v    = 1'b1;
        e_d.dest = sb.id_dest;
        e_d.ld   = sb.id_mem_read;
      end
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign sb.stall     = stall;
  assign sb.bubble    = bubble;
  assign sb.flush     = flush;
  assign sb.stall_cnt = stall_cnt_q;
  assign sb.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Drives four differently configured hazard controllers with one shared
// instruction stream and compares them against an age-window reference model.
module tb_hazard_scoreboard;

  localparam int          NCFG        = 4;
  localparam bit          FW  [NCFG]  = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam bit          WBB [NCFG]  = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam bit          R0H [NCFG]  = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam int unsigned CW  [NCFG]  = '{16, 16, 4, 8};

  typedef struct {
    bit v;
    int s1;
    int s2;
    bit u2;
    bit wb;
    int d;
    bit ld;
    bit br;
    bit frz;
  } ins_t;

  // One issued instruction as seen by the model, indexed by age (0 = in EXE).
  typedef struct {
    bit wr;
    int dest;
    bit ld;
  } rec_t;

  logic       clk;
  logic       rst;
  logic       id_valid, id_use_src2, id_wb_en, id_mem_read, br_taken, mem_freeze;
  logic [4:0] id_src1, id_src2, id_dest;

  logic [NCFG-1:0] stall_o, bubble_o, flush_o;
  logic [31:0]     scnt_o [NCFG];
  logic [31:0]     fcnt_o [NCFG];

  int          n_checks;
  int          n_errors;
  rec_t        hist [NCFG][3];
  int unsigned m_scnt [NCFG];
  int unsigned m_fcnt [NCFG];

  ins_t add3, sub4, nop, ld7, add8, addi7, addi0, add_r0, st3, cur;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    hazard_scoreboard_if #(.CNT_W(CW[g])) bus ();
    assign bus.id_valid    = id_valid;
    assign bus.id_src1     = id_src1;
    assign bus.id_src2     = id_src2;
    assign bus.id_use_src2 = id_use_src2;
    assign bus.id_wb_en    = id_wb_en;
    assign bus.id_dest     = id_dest;
    assign bus.id_mem_read = id_mem_read;
    assign bus.br_taken    = br_taken;
    assign bus.mem_freeze  = mem_freeze;

    hazard_scoreboard #(
      .FWD_EN(FW[g]),
      .WB_BYPASS(WBB[g]),
      .R0_HARDWIRED(R0H[g]),
      .CNT_W(CW[g])
    ) dut (
      .clk(clk),
      .rst(rst),
      .sb(bus)
    );

    assign stall_o[g]  = bus.stall;
    assign bubble_o[g] = bus.bubble;
    assign flush_o[g]  = bus.flush;
    assign scnt_o[g]   = 32'(bus.stall_cnt);
    assign fcnt_o[g]   = 32'(bus.flush_cnt);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t mk(bit v, int s1, int s2, bit u2, bit wb, int d, bit ld);
    ins_t r;
    r.v = v; r.s1 = s1; r.s2 = s2; r.u2 = u2; r.wb = wb; r.d = d; r.ld = ld;
    r.br = 1'b0; r.frz = 1'b0;
    return r;
  endfunction

  // A writer of r is a hazard if the reader is still inside its exposure
  // window: only the youngest load with forwarding, otherwise EXE and MEM
  // (plus WB when the register file cannot bypass).
  function automatic bit model_hz(int k, ins_t i);
    bit hz = 1'b0;
    for (int a = 0; a < 3; a++) begin
      rec_t r;
      bit reads, live;
      r = hist[k][a];
      reads = (r.dest == i.s1) || (i.u2 && (r.dest == i.s2));
      if (!r.wr || !reads || (R0H[k] && (r.dest == 0))) continue;
      live = FW[k] ? ((a == 0) && r.ld) : ((a < 2) || !WBB[k]);
      hz |= live;
    end
    return i.v && hz;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      for (int a = 0; a < 3; a++) hist[k][a] = '{wr: 1'b0, dest: 0, ld: 1'b0};
      m_scnt[k] = 0;
      m_fcnt[k] = 0;
    end
  endtask

  task automatic step(input ins_t i);
    @(negedge clk);
    id_valid    = i.v;
    id_src1     = 5'(i.s1);
    id_src2     = 5'(i.s2);
    id_use_src2 = i.u2;
    id_wb_en    = i.wb;
    id_dest     = 5'(i.d);
    id_mem_read = i.ld;
    br_taken    = i.br;
    mem_freeze  = i.frz;
    #1;
    for (int k = 0; k < NCFG; k++) begin
      bit exp_stall, exp_flush, exp_bub;
      int unsigned maxv;
      exp_flush = i.br;
      exp_stall = model_hz(k, i) && !i.br;
      exp_bub   = exp_stall || exp_flush;
      check($sformatf("stall%0d", k), 32'(stall_o[k]), 32'(exp_stall));
      check($sformatf("bubble%0d", k), 32'(bubble_o[k]), 32'(exp_bub));
      check($sformatf("flush%0d", k), 32'(flush_o[k]), 32'(exp_flush));
      check($sformatf("stall_cnt%0d", k), scnt_o[k], m_scnt[k]);
      check($sformatf("flush_cnt%0d", k), fcnt_o[k], m_fcnt[k]);
      if (!i.frz) begin
        maxv = (32'd1 << CW[k]) - 32'd1;
        hist[k][2] = hist[k][1];
        hist[k][1] = hist[k][0];
        hist[k][0] = '{wr: i.v && i.wb && !exp_bub, dest: i.d, ld: i.ld};
        if (exp_stall && (m_scnt[k] < maxv)) m_scnt[k]++;
        if (exp_flush && (m_fcnt[k] < maxv)) m_fcnt[k]++;
      end
    end
  endtask

  // Called just after a step; raises rst between clock edges.
  task automatic async_reset();
    #2;
    br_taken = 1'b1;
    rst      = 1'b1;
    #1;
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("rst_stall%0d", k), 32'(stall_o[k]), 32'd0);
      check($sformatf("rst_flush%0d", k), 32'(flush_o[k]), 32'd0);
      check($sformatf("rst_bubble%0d", k), 32'(bubble_o[k]), 32'd0);
      check($sformatf("rst_scnt%0d", k), scnt_o[k], 32'd0);
      check($sformatf("rst_fcnt%0d", k), fcnt_o[k], 32'd0);
    end
    model_reset();
    @(negedge clk);
    id_valid   = 1'b0;
    br_taken   = 1'b0;
    mem_freeze = 1'b0;
    rst        = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_use_src2 = 1'b0;
    id_wb_en = 1'b0; id_dest = '0; id_mem_read = 1'b0;
    br_taken = 1'b0; mem_freeze = 1'b0;
    model_reset();

    add3   = mk(1, 1, 2, 1, 1, 3, 0);
    sub4   = mk(1, 3, 5, 1, 1, 4, 0);
    nop    = mk(0, 0, 0, 0, 0, 0, 0);
    ld7    = mk(1, 2, 0, 0, 1, 7, 1);
    add8   = mk(1, 7, 1, 1, 1, 8, 0);
    addi7  = mk(1, 1, 0, 0, 1, 7, 0);
    addi0  = mk(1, 1, 0, 0, 1, 0, 0);
    add_r0 = mk(1, 0, 2, 1, 1, 5, 0);
    st3    = mk(1, 1, 3, 0, 0, 0, 0);

    #1;
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("init_stall%0d", k), 32'(stall_o[k]), 32'd0);
      check($sformatf("init_scnt%0d", k), scnt_o[k], 32'd0);
      check($sformatf("init_fcnt%0d", k), fcnt_o[k], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // RAW back-to-back: two stall cycles, SUB issues on the third.
    step(add3);
    step(sub4); check("raw_c1", 32'(stall_o[0]), 32'd1);
    step(sub4); check("raw_c2", 32'(stall_o[0]), 32'd1);
    step(sub4); check("raw_c3", 32'(stall_o[0]), 32'd0);
    step(nop);  check("raw_cnt", scnt_o[0], 32'd2);

    // Load-use with forwarding: one stall; ALU producer: none.
    async_reset();
    step(ld7);
    step(add8); check("lu_c1", 32'(stall_o[1]), 32'd1);
    step(add8); check("lu_c2", 32'(stall_o[1]), 32'd0);
    step(nop); step(nop); step(nop);
    step(addi7);
    step(add8); check("alu_fwd", 32'(stall_o[1]), 32'd0);

    // Taken branch against a dependent instruction in ID.
    async_reset();
    step(add3);
    cur = sub4; cur.br = 1'b1;
    step(cur);
    check("br_flush", 32'(flush_o[0]), 32'd1);
    check("br_stall", 32'(stall_o[0]), 32'd0);
    check("br_bubble", 32'(bubble_o[0]), 32'd1);
    step(nop);
    check("br_fcnt", fcnt_o[0], 32'd1);
    check("br_scnt", scnt_o[0], 32'd0);

    // Freeze held across the first stall cycle.
    async_reset();
    step(add3);
    cur = sub4; cur.frz = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step(cur); check("frz_hold", 32'(stall_o[0]), 32'd1);
    end
    step(sub4); check("frz_rel1", 32'(stall_o[0]), 32'd1);
    step(sub4); check("frz_rel2", 32'(stall_o[0]), 32'd1);
    step(sub4); check("frz_rel3", 32'(stall_o[0]), 32'd0);
    check("frz_cnt", scnt_o[0], 32'd2);

    // R0 hardwiring and an unread src2.
    async_reset();
    step(addi0);
    step(add_r0);
    check("r0_soft", 32'(stall_o[0]), 32'd1);
    check("r0_hard", 32'(stall_o[2]), 32'd0);
    step(add_r0); step(add_r0);
    step(nop); step(nop); step(nop);
    step(add3);
    step(st3); check("src2_unused", 32'(stall_o[0]), 32'd0);

    // Asynchronous reset in the middle of a stall.
    step(nop); step(nop);
    step(add3);
    step(sub4); check("pre_rst_stall", 32'(stall_o[0]), 32'd1);
    async_reset();

    // Ten RAW pairs: 20 stall cycles saturate the 4-bit counter.
    for (int n = 0; n < 10; n++) begin
      step(add3); step(sub4); step(sub4); step(sub4);
    end
    step(nop);
    check("sat_cnt4", scnt_o[2], 32'd15);
    check("sat_cnt16", scnt_o[0], 32'd20);

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      cur.v   = ($urandom_range(0, 9) != 0);
      cur.s1  = $urandom_range(0, 3);
      cur.s2  = $urandom_range(0, 3);
      cur.u2  = $urandom_range(0, 1);
      cur.wb  = ($urandom_range(0, 4) != 0);
      cur.d   = $urandom_range(0, 3);
      cur.ld  = ($urandom_range(0, 2) == 0);
      cur.br  = ($urandom_range(0, 9) == 0);
      cur.frz = ($urandom_range(0, 4) == 0);
      step(cur);
      if ((n % 150) == 149) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
